// File: rtl/alu_op_sequencer_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: operations, FSM states,
// default operand width and the single-bit operation used by the logic cell.
package alu_op_sequencer_pkg;

  localparam int default_size = 8;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic alu_bit(input alu_op_e op, input logic a, input logic b);
    logic y;
    y = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle between a requester and the ALU sequencer.
interface alu_op_sequencer_if #(
  parameter int size = alu_op_sequencer_pkg::default_size
) ();

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [size-1:0] in_a;
  logic [size-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [size-1:0] out_c;
  logic            out_zero;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_c, out_zero
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_c, out_zero
  );

endinterface

// File: rtl/alu_op_sequencer_bit_logic_cell.sv
// One-bit combinational operation cell; the sequencer feeds it one operand bit pair per clock.
module bit_logic_cell
  import alu_op_sequencer_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    y = alu_bit(alu_op_e'(op), a, b);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Bit-serial bitwise ALU: operands latched on accept, one result bit per clock, LSB first.
// state | meaning
// IDLE  | ready to accept a request
// EXEC  | computing result bit cnt_q
// DONE  | result presented on out_c until the consumer takes it
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int size = default_size
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave bus,
  output logic              busy
);

  localparam int cnt_w = (size > 1) ? $clog2(size) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(size - 1);

  state_e          state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [size-1:0] a_q, a_d;
  logic [size-1:0] b_q, b_d;
  logic [size-1:0] res_q, res_d;
  logic [size-1:0] out_c_q, out_c_d;
  logic            out_zero_q, out_zero_d;
  logic [size-1:0] res_final;
  logic            bit_y;
  logic            in_ready_w;

  bit_logic_cell u_cell (
    .a  (a_q[cnt_q]),
    .b  (b_q[cnt_q]),
    .op (op_q),
    .y  (bit_y)
  );

  assign in_ready_w = (state_q == ST_IDLE) && !rst;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    out_c_d    = out_c_q;
    out_zero_d = out_zero_q;
    res_final  = res_q;
    res_final[cnt_q] = bit_y;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_w) begin
          state_d = ST_EXEC;
          cnt_d   = '0;
          op_d    = bus.in_op;
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          res_d   = '0;
        end
      end
      ST_EXEC: begin
        res_d = res_final;
        // out_c only changes here, so the previous result survives the whole EXEC phase
        if (cnt_q == cnt_last) begin
          state_d    = ST_DONE;
          cnt_d      = '0;
          out_c_d    = res_final;
          out_zero_d = (res_final == '0);
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      out_c_q    <= '0;
      out_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      out_c_q    <= out_c_d;
      out_zero_q <= out_zero_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_c     = out_c_q;
  assign bus.out_zero  = out_zero_q;
  assign busy          = (state_q == ST_EXEC) || (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer (size = 8) against a whole-word reference model.
module tb_alu_op_sequencer;

  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   failures;

  alu_op_sequencer_if #(.size(8)) bus ();

  alu_op_sequencer #(.size(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_c(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, then waits for out_valid; lat = edges from acceptance, -1 on timeout.
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit scramble, output int lat, output logic [7:0] c, output logic z);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    tick();
    bus.in_valid = 1'b0;
    lat = -1;
    n   = 0;
    while (n < 40) begin
      if (scramble) begin
        bus.in_a     = 8'($urandom);
        bus.in_b     = 8'($urandom);
        bus.in_op    = 2'($urandom);
        bus.in_valid = 1'($urandom);
      end
      tick();
      n++;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
    bus.in_valid = 1'b0;
    c = bus.out_c;
    z = bus.out_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready_low got=%b want=0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_c !== 8'h00 || bus.out_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b busy=%b c=%h z=%b want 0 0 00 0",
               bus.out_valid, busy, bus.out_c, bus.out_zero);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_in_ready got=%b want=1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [1:0] ops [4];
    logic [7:0] as [4];
    logic [7:0] bs [4];
    logic [7:0] cs [4];
    logic       zs [4];
    int lat;
    logic [7:0] c;
    logic z;
    ops = '{2'b00, 2'b10, 2'b11, 2'b01};
    as  = '{8'hF0, 8'hA5, 8'h00, 8'h81};
    bs  = '{8'h3C, 8'hA5, 8'h00, 8'h18};
    cs  = '{8'h30, 8'h00, 8'hFF, 8'h99};
    zs  = '{1'b0, 1'b1, 1'b0, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, lat, c, z);
      checks++;
      if (lat !== 8) begin
        failures++;
        $display("FAIL directed_latency[%0d] got=%0d want=8", i, lat);
      end
      checks++;
      if (c !== cs[i] || z !== zs[i]) begin
        failures++;
        $display("FAIL directed_result[%0d] got c=%h z=%b want c=%h z=%b", i, c, z, cs[i], zs[i]);
      end
    end
    tick();
  endtask

  task automatic test_retain();
    logic [7:0] c;
    logic z;
    int lat;
    bus.out_ready = 1'b1;
    run_op(2'b01, 8'h5A, 8'h03, 1'b0, lat, c, z);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.out_c !== 8'h5B || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL retain_after_done got c=%h valid=%b busy=%b rdy=%b want c=5b valid=0 busy=0 rdy=1",
               bus.out_c, bus.out_valid, busy, bus.in_ready);
    end
  endtask

  task automatic test_operand_change();
    logic [1:0] op;
    logic [7:0] a, b, c;
    logic z;
    int lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      run_op(op, a, b, 1'b1, lat, c, z);
      checks++;
      if (lat !== 8 || c !== ref_c(op, a, b) || z !== (ref_c(op, a, b) == 8'h00)) begin
        failures++;
        $display("FAIL operand_change[%0d] got lat=%0d c=%h z=%b want lat=8 c=%h z=%b",
                 i, lat, c, z, ref_c(op, a, b), (ref_c(op, a, b) == 8'h00));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] c, c2;
    logic z, z2;
    int lat;
    bus.out_ready = 1'b0;
    run_op(2'b10, 8'h3C, 8'h0F, 1'b0, lat, c, z);
    checks++;
    if (lat !== 8 || c !== 8'h33) begin
      failures++;
      $display("FAIL bp_first got lat=%0d c=%h want lat=8 c=33", lat, c);
    end
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b01;
    bus.in_a     = 8'h81;
    bus.in_b     = 8'h42;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.out_c !== 8'h33 || bus.out_zero !== 1'b0 || bus.in_ready !== 1'b0 ||
          bus.out_valid !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d] got c=%h z=%b rdy=%b valid=%b busy=%b want 33 0 0 1 1",
                 i, bus.out_c, bus.out_zero, bus.in_ready, bus.out_valid, busy);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_c !== 8'h33) begin
      failures++;
      $display("FAIL bp_release got rdy=%b valid=%b c=%h want 1 0 33", bus.in_ready, bus.out_valid, bus.out_c);
    end
    run_op(2'b01, 8'h81, 8'h42, 1'b0, lat, c2, z2);
    checks++;
    if (lat !== 8 || c2 !== 8'hC3 || z2 !== 1'b0) begin
      failures++;
      $display("FAIL bp_second got lat=%0d c=%h z=%b want lat=8 c=c3 z=0", lat, c2, z2);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] c;
    logic z;
    int lat;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_op     = 2'b01;
    bus.in_a      = 8'hFF;
    bus.in_b      = 8'h00;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL exec_rst_in_ready got=%b want=0", bus.in_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_c !== 8'h00 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL exec_rst_state got valid=%b c=%h rdy=%b busy=%b want 0 00 1 0",
               bus.out_valid, bus.out_c, bus.in_ready, busy);
    end
    run_op(2'b00, 8'hFF, 8'h0F, 1'b0, lat, c, z);
    checks++;
    if (lat !== 8 || c !== 8'h0F || z !== 1'b0) begin
      failures++;
      $display("FAIL exec_rst_next got lat=%0d c=%h z=%b want lat=8 c=0f z=0", lat, c, z);
    end
    tick();
    bus.out_ready = 1'b0;
    run_op(2'b11, 8'h01, 8'h02, 1'b0, lat, c, z);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_c !== 8'h00 || bus.out_zero !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL done_rst_drop got valid=%b c=%h z=%b rdy=%b want 0 00 0 1",
               bus.out_valid, bus.out_c, bus.out_zero, bus.in_ready);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_c [$];
    logic [7:0] e;
    int  last;
    int  accepts;
    int  results;
    bit  acc;
    last    = -1;
    accepts = 0;
    results = 0;
    bus.out_ready = 1'b1;
    bus.in_op     = 2'b00;
    bus.in_a      = 8'($urandom);
    bus.in_b      = 8'($urandom);
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 65; i++) begin
      acc = bus.in_valid && bus.in_ready;
      if (acc) exp_c.push_back(ref_c(bus.in_op, bus.in_a, bus.in_b));
      tick();
      if (acc) begin
        if (last >= 0) begin
          checks++;
          if (i - last !== 10) begin
            failures++;
            $display("FAIL b2b_interval got=%0d want=10", i - last);
          end
        end
        last = i;
        accepts++;
        bus.in_op = (accepts % 2 == 1) ? 2'b10 : 2'b11;
        bus.in_a  = 8'($urandom);
        bus.in_b  = 8'($urandom);
      end
      if (bus.out_valid) begin
        e = (exp_c.size() > 0) ? exp_c.pop_front() : 8'hxx;
        results++;
        checks++;
        if (bus.out_c !== e || bus.out_zero !== (e == 8'h00)) begin
          failures++;
          $display("FAIL b2b_result[%0d] got c=%h z=%b want c=%h", results, bus.out_c, bus.out_zero, e);
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (accepts !== 7 || results !== 6) begin
      failures++;
      $display("FAIL b2b_counts got accepts=%0d results=%0d want 7 6", accepts, results);
    end
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [7:0] a, b, c;
    logic z;
    int lat;
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom);
      a  = 8'($urandom);
      b  = (i % 5 == 0) ? a : 8'($urandom);
      bus.out_ready = 1'b1;
      run_op(op, a, b, 1'b0, lat, c, z);
      checks++;
      if (lat !== 8 || c !== ref_c(op, a, b) || z !== (ref_c(op, a, b) == 8'h00)) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got lat=%0d c=%h z=%b want lat=8 c=%h",
                 i, op, a, b, lat, c, z, ref_c(op, a, b));
      end
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_retain();
    test_operand_change();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: size, default 8, operand/result width in bits.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  request present on in_op/in_a/in_b.
REQ-005 in_ready  output  1  sequencer can accept a request.
REQ-006 in_op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-007 in_a  input  size  operand A.
REQ-008 in_b  input  size  operand B.
REQ-009 out_valid  output  1  result present on out_c/out_zero.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_c  output  size  bitwise result.
REQ-012 out_zero  output  1  high when out_c is all zeros.
REQ-013 busy  output  1  high in EXEC or DONE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, DONE; in_ready = 1 only in IDLE and with rst low; out_valid = 1 only in DONE.
REQ-015 IDLE: on in_valid && in_ready at edge E0, latch in_op/in_a/in_b, clear bit counter to 0, go to EXEC; otherwise remain in IDLE.
REQ-016 EXEC: each edge computes one result bit, LSB first, result[count] = op(a[count], b[count]), then increments count.
REQ-017 EXEC -> DONE at the edge processing count == size-1; out_valid SHALL rise at edge E0+size (size edges after acceptance).
REQ-018 DONE: out_c and out_zero SHALL hold stable while out_ready is low; on out_valid && out_ready, go to IDLE at that edge.
REQ-019 Back-to-back throughput with out_ready tied high SHALL be one request per size+2 edges; a request is never accepted in EXEC or DONE.
REQ-020 in_valid, in_op, in_a and in_b SHALL be ignored outside IDLE; latched operands SHALL be unaffected by input changes during EXEC.
REQ-021 out_zero SHALL equal (out_c == 0), registered together with the final bit.
REQ-022 Counter width SHALL be clog2(size) bits (minimum 1) and SHALL never exceed size-1.
REQ-023 out_c SHALL retain the last result after the DONE->IDLE transition until the next result completes.

Reset
REQ-024 rst high at an edge SHALL force IDLE, count = 0, out_c = 0, out_zero = 0, out_valid = 0, busy = 0, and latched operands/op = 0.
REQ-025 rst SHALL override all handshakes, including in EXEC (operation abandoned, no partial result) and in DONE (pending result dropped).
REQ-026 in_ready SHALL read 0 while rst is high and 1 in the first cycle after rst deasserts.

Structure
REQ-027 The operation encodings (AND/OR/XOR/NOR), the state encodings and the default size SHALL live in a shared package/include used by the ALU blocks.
REQ-028 A single sub-module bit_logic_cell (1-bit a, b, 2-bit op -> 1-bit y, combinational) SHALL compute each serial bit and be instanced once.
REQ-029 Everything else (FSM, counter, shift/result register) SHALL reside in alu_op_sequencer.

Verification (size = 8)
REQ-030 AND with a=8'hF0, b=8'h3C -> out_c=8'h30, out_zero=0, out_valid rises exactly 8 edges after the accepting edge.
REQ-031 XOR with a=b=8'hA5 -> out_c=8'h00, out_zero=1; NOR with a=b=8'h00 -> out_c=8'hFF; OR with 8'h81, 8'h18 -> out_c=8'h99.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE while presenting a new in_valid request -> out_c is stable, in_ready=0, the new request is accepted only after out_ready=1.
REQ-033 rst pulse at count=3 of EXEC -> next cycle state IDLE, out_valid=0, out_c=0, in_ready=1; next AND 8'hFF & 8'h0F -> 8'h0F.
REQ-034 in_valid and out_ready tied high with alternating requests -> exactly one acceptance per 10 edges and results in request order.
REQ-035 Change in_a/in_b every cycle during EXEC -> result matches the operands latched at acceptance.
